// File: rtl/hi_lo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : hi_lo_muldiv_unit
// Description : Iterative multiply/divide unit owning the HI/LO registers.
//               Radix-2 shift-add multiplier and restoring divider, one
//               step per clock, followed by a sign-fix/commit cycle.
//               MTHI/MTLO write HI/LO directly while idle.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-high reset
//               start      - one-cycle request strobe, qualified by op
//               op         - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                            101 MTHI, 110 MTLO, others no-op
//               abort      - cancels an in-flight operation
//               operand_a  - rs (multiplicand / dividend / MTHI-MTLO data)
//               operand_b  - rt (multiplier / divisor)
//               busy       - operation in flight (registered)
//               done       - one-cycle pulse after a mul/div commit
//               hi, lo     - HI/LO architectural registers
// Revision    : 1.0 - initial release
// ============================================================================
module hi_lo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_param_check
      $error("hi_lo_muldiv_unit: WIDTH must be >= 4 and even");
    end
  endgenerate

  localparam logic [2:0] c_OP_MULT  = 3'b001;
  localparam logic [2:0] c_OP_MULTU = 3'b010;
  localparam logic [2:0] c_OP_DIV   = 3'b011;
  localparam logic [2:0] c_OP_DIVU  = 3'b100;
  localparam logic [2:0] c_OP_MTHI  = 3'b101;
  localparam logic [2:0] c_OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Datapath registers.
  //   r_acc : upper product half (mul) / partial remainder (div)
  //   r_q   : multiplier shifting out, low product half shifting in (mul);
  //           dividend shifting out, quotient shifting in (div)
  //   r_opb : multiplicand magnitude (mul) / divisor magnitude (div)
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Request decode
  logic w_accept;
  logic w_op_mul;
  logic w_op_div;
  logic w_op_signed;
  logic w_start_arith;

  assign w_accept      = (r_state == S_IDLE) && start && !abort;
  assign w_op_mul      = (op == c_OP_MULT) || (op == c_OP_MULTU);
  assign w_op_div      = (op == c_OP_DIV)  || (op == c_OP_DIVU);
  assign w_op_signed   = (op == c_OP_MULT) || (op == c_OP_DIV);
  assign w_start_arith = w_accept && (w_op_mul || w_op_div);

  // Operand magnitudes: two's-complement absolute value for signed ops.
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude 2^(WIDTH-1).
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_a_neg = w_op_signed && operand_a[WIDTH-1];
  assign w_b_neg = w_op_signed && operand_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~operand_a + 1'b1) : operand_a;
  assign w_b_mag = w_b_neg ? (~operand_b + 1'b1) : operand_b;

  // Multiply step: add multiplicand when the current multiplier LSB is set,
  // then shift the whole {carry, acc, q} right by one.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

  // Divide step: shift next dividend MSB into the remainder and trial-subtract.
  // The shifted remainder is WIDTH+1 bits wide; when it is not below the
  // divisor the difference is smaller than the divisor, so its low WIDTH bits
  // are exact. A zero divisor always "succeeds", giving an all-ones quotient
  // and a remainder equal to the dividend.
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;

  assign w_div_shift = {r_acc, r_q[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_neg_q ? (~r_q + 1'b1)    : r_q;
  assign w_rem_fix  = r_neg_r ? (~r_acc + 1'b1)  : r_acc;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_arith) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_LAST_CNT) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX) && !abort;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_arith) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= w_op_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_op_div) begin
              r_q   <= w_a_mag;
              r_opb <= w_b_mag;
            end else begin
              r_q   <= w_b_mag;
              r_opb <= w_a_mag;
            end
          end else if (w_accept && (op == c_OP_MTHI)) begin
            r_hi <= operand_a;
          end else if (w_accept && (op == c_OP_MTLO)) begin
            r_lo <= operand_a;
          end
        end
        S_RUN: begin
          if (!abort) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
              r_acc <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], w_div_ge};
            end else begin
              r_acc <= w_mul_sum[WIDTH:1];
              r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!abort) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hi_lo_muldiv_unit
// Description : Scoreboard bench for hi_lo_muldiv_unit (WIDTH=32). Stimulus
//               pushes expected {HI,LO} pairs; a monitor pops and compares
//               on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hi_lo_muldiv_unit;

  localparam int W = 32;

  localparam logic [2:0] c_MULT  = 3'b001;
  localparam logic [2:0] c_MULTU = 3'b010;
  localparam logic [2:0] c_DIV   = 3'b011;
  localparam logic [2:0] c_DIVU  = 3'b100;
  localparam logic [2:0] c_MTHI  = 3'b101;
  localparam logic [2:0] c_MTLO  = 3'b110;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic         abort;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*W-1:0] exp_q[$];

  hi_lo_muldiv_unit #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .abort     (abort),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with no pending result, expected no done");
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("result_hi", hi, e[2*W-1:W]);
        check("result_lo", lo, e[W-1:0]);
      end
    end
  end

  // Called at a negedge; the request is accepted at the following posedge
  // and the task returns at the negedge after it.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    start     = 1'b0;
    op        = 3'b000;
  endtask

  // Waits (bounded) for done, counting busy cycles seen beforehand.
  task automatic wait_done(output int busy_cyc);
    int guard;
    busy_cyc = 0;
    guard    = 0;
    while (done !== 1'b1 && guard < 100) begin
      if (busy === 1'b1) busy_cyc++;
      guard++;
      @(negedge clk);
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int bc;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'b000;
    abort     = 1'b0;
    operand_a = '0;
    operand_b = '0;

    // Reset state
    @(negedge clk);
    check("reset_hi",   hi, 32'h0);
    check("reset_lo",   lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU max operands with latency/busy-width checks
    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    issue(c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(bc);
    check("busy_cycles", bc, 32'd33);
    check("busy_in_done_cycle", {31'd0, busy}, 32'd0);

    // Back-to-back: MULT issued in the done cycle
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    issue(c_MULT, 32'hFFFFFFFD, 32'd7);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(bc);
    check("b2b_busy_cycles", bc, 32'd33);
    @(negedge clk);

    // MTLO while idle
    issue(c_MTLO, 32'h12345678, 32'h0);
    check("mtlo_lo",   lo, 32'h12345678);
    check("mtlo_hi",   hi, 32'hFFFFFFFF);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_done", {31'd0, done}, 32'd0);

    // DIV signed, DIVU by zero, signed overflow
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(c_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(bc);
    exp_q.push_back({32'h00000007, 32'hFFFFFFFF});
    issue(c_DIVU, 32'd7, 32'd0);
    wait_done(bc);
    exp_q.push_back({32'h00000000, 32'h80000000});
    issue(c_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(bc);
    @(negedge clk);

    // Preload, ignored start, abort
    issue(c_MTHI, 32'hAAAA0000, 32'h0);
    issue(c_MTLO, 32'h0000BBBB, 32'h0);
    check("preload_hi", hi, 32'hAAAA0000);
    check("preload_lo", lo, 32'h0000BBBB);
    issue(c_MULTU, 32'd5, 32'd5);            // now in RUN cycle 1
    repeat (2) @(negedge clk);               // RUN cycle 3
    issue(c_DIVU, 32'd100, 32'd3);           // ignored while busy
    check("ignored_start_busy", {31'd0, busy}, 32'd1);
    check("ignored_start_hi", hi, 32'hAAAA0000);
    repeat (6) @(negedge clk);               // RUN cycle 10
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'hAAAA0000);
    check("abort_lo", lo, 32'h0000BBBB);
    exp_q.push_back({32'h0, 32'd6});
    issue(c_MULTU, 32'd2, 32'd3);
    check("post_abort_busy", {31'd0, busy}, 32'd1);
    wait_done(bc);
    @(negedge clk);

    // Abort in IDLE suppresses a simultaneous MTHI
    abort = 1'b1;
    issue(c_MTHI, 32'h55555555, 32'h0);
    abort = 1'b0;
    check("idle_abort_hi", hi, 32'h0);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-RUN
    issue(c_MTHI, 32'h00000001, 32'h0);
    issue(c_MULTU, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_hi",   hi, 32'h0);
    check("async_rst_lo",   lo, 32'h0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    exp_q.push_back({32'h0, 32'd20});
    issue(c_MULTU, 32'd4, 32'd5);
    wait_done(bc);
    check("resume_busy_cycles", bc, 32'd33);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
